sa_autosa_pdp_pool1d: RTL and testbench



---
 rtl/sa_autosa_pdp_pool1d.sv | 100 ++++++++++
 tb/tb_sa_autosa_pdp_pool1d.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sa_autosa_pdp_pool1d.sv
// sa_autosa_pdp_pool1d: streaming 1-D max/sum pooling over non-overlapping windows within a line,
// one widened result per window, with a done pulse per configured surface.
module sa_autosa_pdp_pool1d #(
    parameter int DW = 8,
    parameter int KW = 3,
    parameter int CW = 13
) (
    input  logic          autosa_core_clk,
    input  logic          autosa_core_rst,
    input  logic          op_en,
    input  logic          cfg_pool_mode,
    input  logic [KW-1:0] cfg_kernel,
    input  logic [CW-1:0] cfg_width,
    input  logic [CW-1:0] cfg_height,
    input  logic          sdp2pdp_valid,
    output logic          sdp2pdp_ready,
    input  logic [DW-1:0] sdp2pdp_pd,
    output logic          pool_valid,
    input  logic          pool_ready,
    output logic [DW+2:0] pool_pd,
    output logic          pool_last,
    output logic          pdp_busy,
    output logic          pdp2glb_done_intr
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic mode;
    logic [KW-1:0] kern, win_cnt;
    logic [CW-1:0] width, height, col_cnt, row_cnt;
    logic signed [DW+2:0] acc, x_ext, comb;
    logic accept, line_end, close;
    // once the final result is latched the input side stays closed until the surface completes
    assign sdp2pdp_ready = state == RUN && !(pool_valid && pool_last) && (!pool_valid || pool_ready);
    assign accept = sdp2pdp_ready && sdp2pdp_valid;
    assign line_end = col_cnt == width;
    assign close = win_cnt == kern || line_end;
    always_comb begin
        x_ext = {{3{sdp2pdp_pd[DW-1]}}, sdp2pdp_pd};
        comb = win_cnt == '0 ? x_ext : mode ? acc + x_ext : (x_ext > acc ? x_ext : acc);
    end
    always_ff @(posedge autosa_core_clk or posedge autosa_core_rst) begin
        if (autosa_core_rst) begin
            state <= IDLE;
            mode <= 1'b0;
            kern <= '0;
            width <= '0;
            height <= '0;
            win_cnt <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            acc <= '0;
            pool_valid <= 1'b0;
            pool_pd <= '0;
            pool_last <= 1'b0;
            pdp_busy <= 1'b0;
            pdp2glb_done_intr <= 1'b0;
        end else begin
            case (state)
                IDLE: if (op_en) begin
                    state <= RUN;
                    mode <= cfg_pool_mode;
                    kern <= cfg_kernel;
                    width <= cfg_width;
                    height <= cfg_height;
                    win_cnt <= '0;
                    col_cnt <= '0;
                    row_cnt <= '0;
                    pool_last <= 1'b0;
                    pdp_busy <= 1'b1;
                end
                RUN: begin
                    if (pool_valid && pool_ready) begin
                        pool_valid <= 1'b0;
                        if (pool_last) begin
                            state <= DONE;
                            pdp2glb_done_intr <= 1'b1;
                        end
                    end
                    if (accept) begin
                        acc <= comb;
                        win_cnt <= close ? '0 : win_cnt + 1'b1;
                        col_cnt <= line_end ? '0 : col_cnt + 1'b1;
                        row_cnt <= line_end ? row_cnt + 1'b1 : row_cnt;
                        if (close) begin
                            pool_pd <= comb;
                            pool_valid <= 1'b1;
                            pool_last <= line_end && row_cnt == height;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    pdp2glb_done_intr <= 1'b0;
                    pdp_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sa_autosa_pdp_pool1d.sv
// tb_sa_autosa_pdp_pool1d: table-driven directed cases, corner sequences and randomized runs
// checked against a window-reduction reference model.
module tb_sa_autosa_pdp_pool1d;
    logic clk = 1'b0, rst = 1'b1;
    logic op_en = 1'b0, cfg_pool_mode = 1'b0;
    logic [2:0] cfg_kernel = '0;
    logic [12:0] cfg_width = '0, cfg_height = '0;
    logic sdp2pdp_valid = 1'b0, sdp2pdp_ready;
    logic [7:0] sdp2pdp_pd = '0;
    logic pool_valid, pool_ready = 1'b0, pool_last, pdp_busy, pdp2glb_done_intr;
    logic [10:0] pool_pd;

    always #5 clk = ~clk;

    sa_autosa_pdp_pool1d dut (
        .autosa_core_clk(clk), .autosa_core_rst(rst), .op_en(op_en),
        .cfg_pool_mode(cfg_pool_mode), .cfg_kernel(cfg_kernel), .cfg_width(cfg_width),
        .cfg_height(cfg_height), .sdp2pdp_valid(sdp2pdp_valid), .sdp2pdp_ready(sdp2pdp_ready),
        .sdp2pdp_pd(sdp2pdp_pd), .pool_valid(pool_valid), .pool_ready(pool_ready),
        .pool_pd(pool_pd), .pool_last(pool_last), .pdp_busy(pdp_busy),
        .pdp2glb_done_intr(pdp2glb_done_intr)
    );

    int n_vec = 0, n_err = 0;
    int elems[$], got_pd[$], exp_q[$];
    bit got_last[$];

    typedef struct {
        bit m;
        int k, w, h, stall;
        bit poke;
        int seq[4];
        int n, first, lst;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference: every line split into consecutive chunks of k, last chunk possibly short
    function automatic void model(input bit m, input int k, input int w, input int h);
        int v;
        exp_q.delete();
        for (int r = 0; r < h; r++)
            for (int c0 = 0; c0 < w; c0 += k) begin
                v = elems[r*w + c0];
                for (int c = c0 + 1; c < c0 + k && c < w; c++)
                    v = m ? v + elems[r*w + c] : (elems[r*w + c] > v ? elems[r*w + c] : v);
                exp_q.push_back(v);
            end
    endfunction

    task automatic run(input bit m, input int k, input int w, input int h,
                       input int stall, input bit poke, input bit gaps);
        int idx, last_hs, done_cyc, held;
        bit hold;
        idx = 0; last_hs = -10; done_cyc = -1; hold = 0; held = 0;
        got_pd.delete(); got_last.delete();
        @(negedge clk);
        cfg_pool_mode = m; cfg_kernel = 3'(k - 1); cfg_width = 13'(w - 1); cfg_height = 13'(h - 1);
        op_en = 1'b1;
        @(negedge clk);
        op_en = 1'b0;
        for (int cyc = 0; cyc < 5000 && done_cyc < 0; cyc++) begin
            if (poke && cyc == 3) begin
                op_en = 1'b1; cfg_pool_mode = !m; cfg_kernel = 3'd0; cfg_width = 13'd1; cfg_height = 13'd0;
            end else op_en = 1'b0;
            pool_ready = stall == 0 ? 1'b1 : stall == 1 ? !(cyc >= 2 && cyc < 7) : ($urandom_range(0, 2) != 0);
            sdp2pdp_valid = idx < elems.size() && (!gaps || $urandom_range(0, 3) != 0);
            sdp2pdp_pd = sdp2pdp_valid ? 8'(elems[idx]) : 8'($urandom);
            #1;
            if (cyc == 0) chk("busy_run", int'(pdp_busy), 1);
            if (hold) chk("hold_pd", int'(pool_pd), held);
            if (pool_valid && !pool_ready) chk("stall_ready", int'(sdp2pdp_ready), 0);
            if (pdp2glb_done_intr) begin
                done_cyc = cyc;
                chk("done_timing", cyc, last_hs + 1);
                chk("busy_in_done", int'(pdp_busy), 1);
            end
            if (pool_valid && pool_ready) begin
                got_pd.push_back(int'($signed(pool_pd)));
                got_last.push_back(pool_last);
                last_hs = cyc;
            end
            hold = pool_valid && !pool_ready;
            held = int'(pool_pd);
            if (sdp2pdp_valid && sdp2pdp_ready) idx++;
            @(negedge clk);
        end
        op_en = 1'b0; sdp2pdp_valid = 1'b0; pool_ready = 1'b1;
        chk("done_seen", int'(done_cyc >= 0), 1);
        chk("all_consumed", idx, elems.size());
        #1;
        chk("done_single", int'(pdp2glb_done_intr), 0);
        chk("busy_after", int'(pdp_busy), 0);
        model(m, k, w, h);
        chk("n_results", got_pd.size(), exp_q.size());
        for (int i = 0; i < got_pd.size() && i < exp_q.size(); i++) begin
            chk("result", got_pd[i], exp_q[i]);
            chk("last_flag", int'(got_last[i]), int'(i == exp_q.size() - 1));
        end
    endtask

    task automatic fill(input int n, input int seq[4]);
        elems.delete();
        for (int i = 0; i < n; i++) elems.push_back(seq[i % 4]);
    endtask

    initial begin
        tbl[0] = '{1'b0, 2, 4, 1, 0, 1'b0, '{3, -5, 7, 7}, 2, 3, 7};
        tbl[1] = '{1'b1, 3, 5, 2, 0, 1'b0, '{127, 127, 127, 127}, 4, 381, 254};
        tbl[2] = '{1'b1, 8, 8, 1, 0, 1'b0, '{-128, -128, -128, -128}, 1, -1024, -1024};
        tbl[3] = '{1'b0, 2, 4, 1, 1, 1'b0, '{3, -5, 7, 7}, 2, 3, 7};
        tbl[4] = '{1'b0, 2, 4, 1, 0, 1'b1, '{3, -5, 7, 7}, 2, 3, 7};
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", int'(sdp2pdp_ready), 0);
        chk("rst_valid", int'(pool_valid), 0);
        chk("rst_pd", int'(pool_pd), 0);
        chk("rst_last", int'(pool_last), 0);
        chk("rst_busy", int'(pdp_busy), 0);
        chk("rst_done", int'(pdp2glb_done_intr), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            fill(tbl[t].w * tbl[t].h, tbl[t].seq);
            run(tbl[t].m, tbl[t].k, tbl[t].w, tbl[t].h, tbl[t].stall, tbl[t].poke, 1'b0);
            chk("tab_n", got_pd.size(), tbl[t].n);
            if (got_pd.size() > 0) begin
                chk("tab_first", got_pd[0], tbl[t].first);
                chk("tab_lastval", got_pd[got_pd.size() - 1], tbl[t].lst);
            end
        end
        // reset in the middle of a line while a result is pending
        @(negedge clk);
        cfg_pool_mode = 1'b0; cfg_kernel = 3'd1; cfg_width = 13'd3; cfg_height = 13'd0; op_en = 1'b1;
        @(negedge clk);
        op_en = 1'b0; pool_ready = 1'b0; sdp2pdp_valid = 1'b1; sdp2pdp_pd = 8'd3;
        @(negedge clk);
        sdp2pdp_pd = 8'hfb;
        @(negedge clk);
        sdp2pdp_valid = 1'b0;
        #1;
        chk("pend_before_rst", int'(pool_valid), 1);
        rst = 1'b1;
        #1;
        chk("abort_valid", int'(pool_valid), 0);
        chk("abort_ready", int'(sdp2pdp_ready), 0);
        chk("abort_busy", int'(pdp_busy), 0);
        chk("abort_pd", int'(pool_pd), 0);
        @(negedge clk);
        rst = 1'b0; pool_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("idle_valid", int'(pool_valid), 0);
            chk("idle_done", int'(pdp2glb_done_intr), 0);
        end
        fill(4, tbl[0].seq);
        run(1'b0, 2, 4, 1, 0, 1'b0, 1'b0);
        chk("restart_n", got_pd.size(), 2);
        // randomized configurations, data, gaps and backpressure
        for (int r = 0; r < 30; r++) begin
            int k, w, h;
            bit m;
            m = 1'($urandom_range(0, 1));
            k = $urandom_range(1, 8);
            w = $urandom_range(1, 24);
            h = $urandom_range(1, 3);
            elems.delete();
            for (int i = 0; i < w * h; i++) elems.push_back(int'($urandom_range(0, 255)) - 128);
            run(m, k, w, h, 2, 1'($urandom_range(0, 1)), 1'b1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
